// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl
// Description : Instruction fetch controller with branch, halt and stall
//               handling, a one-cycle fetch pipeline and a saturating run-cycle
//               counter.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
    parameter int             D          = 12,
    parameter logic [D-1:0]   START_ADDR = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stall,
    input  logic          branch_en,
    input  logic [D-1:0]  branch_target,
    input  logic          halt_req,
    input  logic [8:0]    mach_code,
    output logic [D-1:0]  prog_ctr,
    output logic [8:0]    instr,
    output logic [D-1:0]  instr_pc,
    output logic          instr_valid,
    output logic          busy,
    output logic          done,
    output logic [15:0]   cycle_cnt
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [D-1:0]   r_pc;
    logic [D-1:0]   w_pc_nxt;
    logic [8:0]     r_instr;
    logic [8:0]     w_instr_nxt;
    logic [D-1:0]   r_instr_pc;
    logic [D-1:0]   w_instr_pc_nxt;
    logic           r_valid;
    logic           w_valid_nxt;
    logic [15:0]    r_cnt;
    logic [15:0]    w_cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pc       <= START_ADDR;
            r_instr    <= '0;
            r_instr_pc <= '0;
            r_valid    <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_instr    <= w_instr_nxt;
            r_instr_pc <= w_instr_pc_nxt;
            r_valid    <= w_valid_nxt;
            r_cnt      <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_instr_nxt    = r_instr;
        w_instr_pc_nxt = r_instr_pc;
        w_valid_nxt    = r_valid;
        w_cnt_nxt      = r_cnt;

        case (r_state)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_pc_nxt    = START_ADDR;
                    w_valid_nxt = 1'b0;
                    w_cnt_nxt   = '0;
                end
            end
            S_RUN: begin
                // Counts every RUN edge, stalled or not, including the halting one.
                if (r_cnt != c_CNT_MAX) begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
                // Redirects are only honoured from a valid (correct-path) instruction.
                if (r_valid && halt_req) begin
                    w_state_nxt = S_HALTED;
                    w_valid_nxt = 1'b0;
                end else if (r_valid && branch_en) begin
                    w_pc_nxt    = branch_target;
                    w_valid_nxt = 1'b0;
                end else if (!stall) begin
                    w_instr_nxt    = mach_code;
                    w_instr_pc_nxt = r_pc;
                    w_pc_nxt       = r_pc + 1'b1;
                    w_valid_nxt    = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign prog_ctr    = r_pc;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_valid;
    assign cycle_cnt   = r_cnt;
    assign busy        = (r_state == S_RUN);
    assign done        = (r_state == S_HALTED);

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_ctrl
// Description : Scoreboard bench for fetch_ctrl; directed stimulus, expected
//               fetches queued up front and retired by an independent monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

    localparam int D = 12;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          stall;
    logic          branch_en;
    logic [D-1:0]  branch_target;
    logic          halt_req;
    logic [8:0]    mach_code;
    logic [D-1:0]  prog_ctr;
    logic [8:0]    instr;
    logic [D-1:0]  instr_pc;
    logic          instr_valid;
    logic          busy;
    logic          done;
    logic [15:0]   cycle_cnt;

    logic [8:0]    rom [0:4095];
    logic [20:0]   exp_q [$];
    int            n_vec = 0;
    int            n_err = 0;
    logic          prev_valid = 1'b0;
    logic [D-1:0]  prev_pc = '0;

    fetch_ctrl #(.D(D), .START_ADDR(12'h000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .stall         (stall),
        .branch_en     (branch_en),
        .branch_target (branch_target),
        .halt_req      (halt_req),
        .mach_code     (mach_code),
        .prog_ctr      (prog_ctr),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .busy          (busy),
        .done          (done),
        .cycle_cnt     (cycle_cnt)
    );

    assign mach_code = rom[prog_ctr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input logic [D-1:0] addr);
        exp_q.push_back({rom[addr], addr});
    endtask

    // Retires one queued fetch each time a new valid instruction appears.
    always @(negedge clk) begin
        logic [20:0] e;
        if (rst_n && instr_valid && (!prev_valid || instr_pc != prev_pc)) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_fetch: got pc 0x%0h word 0x%0h, expected none", instr_pc, instr);
            end else begin
                e = exp_q.pop_front();
                check("fetch_word", 32'(instr), 32'(e[20:12]));
                check("fetch_pc", 32'(instr_pc), 32'(e[11:0]));
            end
        end
        prev_valid = rst_n && instr_valid;
        prev_pc    = instr_pc;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 4096; i++) rom[i] = 9'((i * 37 + 11) & 9'h1FF);
        rom[0] = 9'h07E; rom[1] = 9'h066; rom[2] = 9'h07A; rom[3] = 9'h1DE; rom[4] = 9'h17E;
        rst_n = 1'b0; start = 1'b0; stall = 1'b0; branch_en = 1'b0;
        branch_target = '0; halt_req = 1'b0;

        // Reset values before any clock edge.
        #3;
        check("rst_pc", 32'(prog_ctr), 0);
        check("rst_instr", 32'(instr), 0);
        check("rst_instr_pc", 32'(instr_pc), 0);
        check("rst_valid", 32'(instr_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_cnt", 32'(cycle_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("idle_busy", 32'(busy), 0);
        check("idle_pc", 32'(prog_ctr), 0);

        // Run 1: fetch 0..2, branch to 0x010, stall, branch under stall, halt.
        push(12'h000); push(12'h001); push(12'h002);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", 32'(busy), 1);
        check("start_pc", 32'(prog_ctr), 0);
        check("start_valid", 32'(instr_valid), 0);
        check("start_cnt", 32'(cycle_cnt), 0);
        repeat (3) tick();
        check("seq_instr_pc", 32'(instr_pc), 2);
        check("seq_cnt", 32'(cycle_cnt), 3);

        push(12'h010); push(12'h011);
        branch_en = 1'b1; branch_target = 12'h010;
        tick();
        branch_en = 1'b0;
        check("br_pc", 32'(prog_ctr), 12'h010);
        check("br_valid", 32'(instr_valid), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_in_run_pc", 32'(prog_ctr), 12'h011);
        check("start_in_run_cnt", 32'(cycle_cnt), 5);
        tick();
        check("br_seq_pc", 32'(prog_ctr), 12'h012);

        stall = 1'b1;
        repeat (3) tick();
        check("stall_pc", 32'(prog_ctr), 12'h012);
        check("stall_instr_pc", 32'(instr_pc), 12'h011);
        check("stall_instr", 32'(instr), 32'(rom[12'h011]));
        check("stall_valid", 32'(instr_valid), 1);
        check("stall_cnt", 32'(cycle_cnt), 9);

        push(12'h005);
        branch_en = 1'b1; branch_target = 12'h005;
        tick();
        branch_en = 1'b0; stall = 1'b0;
        check("br_stall_pc", 32'(prog_ctr), 12'h005);
        check("br_stall_valid", 32'(instr_valid), 0);
        tick();
        check("pre_halt_instr_pc", 32'(instr_pc), 5);

        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        check("halt_done", 32'(done), 1);
        check("halt_busy", 32'(busy), 0);
        check("halt_pc", 32'(prog_ctr), 6);
        check("halt_instr_pc", 32'(instr_pc), 5);
        check("halt_valid", 32'(instr_valid), 0);
        check("halt_cnt", 32'(cycle_cnt), 12);
        tick();
        check("halted_pc", 32'(prog_ctr), 6);
        check("halted_cnt", 32'(cycle_cnt), 12);
        check("halted_done", 32'(done), 1);

        // Run 2: restart, fetch ROM 0..4, wrap from 0xFFF, saturate counter.
        for (int a = 0; a < 5; a++) push(12'(a));
        push(12'hFFF); push(12'h000);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_pc", 32'(prog_ctr), 0);
        check("restart_cnt", 32'(cycle_cnt), 0);
        check("restart_busy", 32'(busy), 1);
        check("restart_done", 32'(done), 0);
        repeat (5) tick();
        check("seq4_instr", 32'(instr), 9'h17E);
        branch_en = 1'b1; branch_target = 12'hFFF;
        tick();
        branch_en = 1'b0;
        check("br_fff_pc", 32'(prog_ctr), 12'hFFF);
        tick();
        check("wrap_pc", 32'(prog_ctr), 0);
        tick();
        check("wrap_cnt", 32'(cycle_cnt), 8);

        stall = 1'b1;
        repeat (65530) tick();
        stall = 1'b0;
        check("sat_cnt", 32'(cycle_cnt), 16'hFFFF);
        for (int a = 1; a <= 7; a++) push(12'(a));
        repeat (7) tick();
        check("post_sat_instr_pc", 32'(instr_pc), 7);
        check("post_sat_cnt", 32'(cycle_cnt), 16'hFFFF);

        // Asynchronous reset between edges.
        #2 rst_n = 1'b0;
        #1;
        check("async_pc", 32'(prog_ctr), 0);
        check("async_instr", 32'(instr), 0);
        check("async_instr_pc", 32'(instr_pc), 0);
        check("async_valid", 32'(instr_valid), 0);
        check("async_busy", 32'(busy), 0);
        check("async_done", 32'(done), 0);
        check("async_cnt", 32'(cycle_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_busy", 32'(busy), 0);
        check("post_rst_pc", 32'(prog_ctr), 0);
        check("post_rst_valid", 32'(instr_valid), 0);
        check("queue_drained", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
